// File: rtl/mem_arbiter_pkg.sv
// State encoding shared by the mem_arbiter slice.
// Build option MEM_ARB_FIXED_PRIO_EN: undefined by default (round-robin ties); define it for fixed priority to requester 0.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational two-way winner select for mem_arbiter.
// MEM_ARB_FIXED_PRIO_EN defined: requester 0 always wins a tie; otherwise the tie goes to the last loser.
module mem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_gnt_s;
  assign unused_last_gnt_s = last_gnt;
`endif

  // Winner select: a single request wins outright, a tie is resolved by the build option.
  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      gnt_id = 1'b0;
`else
      gnt_id = ~last_gnt;
`endif
    end else if (req1) begin
      gnt_id = 1'b1;
    end else begin
      gnt_id = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer owning a single-port memory; each access is IDLE -> ACCESS -> DONE.
// Build option MEM_ARB_FIXED_PRIO_EN (undefined by default) selects fixed priority in mem_arb_pick.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  wdata0,
  input  logic [WIDTH-1:0]  wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [WIDTH-1:0]  rdata0,
  output logic [WIDTH-1:0]  rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              gnt_valid_s;
  logic              gnt_pick_s;
  logic              load_s;
  logic              access_s;
  logic              done_s;
  logic              mem_we_s;
  logic              gnt_id_r;
  logic              we_lat_r;
  logic              last_gnt_r;
  logic              ack0_r;
  logic              ack1_r;
  logic [WIDTH-1:0]  rdata0_r;
  logic [WIDTH-1:0]  rdata1_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [WIDTH-1:0]  mem_wdata_r;

  mem_arb_pick u_pick (
    .req0      (req0),
    .req1      (req1),
    .last_gnt  (last_gnt_r),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_pick_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: only IDLE looks at requests, so requests during DONE are ignored.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE:   state_nxt_s = gnt_valid_s ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_nxt_s = ST_DONE;
      ST_DONE:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/strobe decode; the write enable is gated by rst_n so a reset edge never commits a write.
  always_comb begin
    load_s   = 1'b0;
    access_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE:   load_s   = gnt_valid_s;
      ST_ACCESS: access_s = 1'b1;
      ST_DONE:   done_s   = 1'b1;
      default:   load_s   = 1'b0;
    endcase
    mem_we_s = access_s & we_lat_r & rst_n;
  end

  // Transaction latches, memory port registers, read-data capture and ack pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_id_r    <= 1'b0;
      we_lat_r    <= 1'b0;
      last_gnt_r  <= 1'b1;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      rdata0_r    <= {WIDTH{1'b0}};
      rdata1_r    <= {WIDTH{1'b0}};
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {WIDTH{1'b0}};
    end else begin
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      if (load_s) begin
        gnt_id_r    <= gnt_pick_s;
        we_lat_r    <= gnt_pick_s ? we1 : we0;
        mem_addr_r  <= gnt_pick_s ? addr1 : addr0;
        mem_wdata_r <= gnt_pick_s ? wdata1 : wdata0;
      end
      // The edge leaving ACCESS is where a read lands and DONE's ack is raised.
      if (access_s) begin
        ack0_r <= ~gnt_id_r;
        ack1_r <= gnt_id_r;
        if (!we_lat_r) begin
          if (gnt_id_r) begin
            rdata1_r <= mem_rdata;
          end else begin
            rdata0_r <= mem_rdata;
          end
        end
      end
      if (done_s) begin
        last_gnt_r <= gnt_id_r;
      end
    end
  end

  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign rdata0    = rdata0_r;
  assign rdata1    = rdata1_r;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule
